// File: rtl/mult4_seq_pkg.sv
// Shared types and constants for the sequential 4x4 multiplier controller.
package mult4_seq_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned P_W  = 8;

  localparam int unsigned SH_LL = 0;
  localparam int unsigned SH_LH = 2;
  localparam int unsigned SH_HL = 2;
  localparam int unsigned SH_HH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LL,
    ST_LH,
    ST_HL,
    ST_HH,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mult2_core.sv
// Exact 2x2 unsigned multiplier producing a 4-bit result.
module mult2_core (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [3:0] p_o
);

  assign p_o = 4'(a_i) * 4'(b_i);

endmodule

// File: rtl/mult4_seq_ctrl.sv
// Sequential 4x4 multiplier: one 2x2 core stepped over four partial products.
module mult4_seq_ctrl
  import mult4_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] A,
  input  logic [OP_W-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [P_W-1:0]  P,
  output logic            busy
);

  state_e           state_q, state_d;
  logic [OP_W-1:0]  a_q, a_d, b_q, b_d;
  logic [P_W-1:0]   acc_q, acc_d, p_q, p_d;
  logic             out_valid_q, out_valid_d, busy_q, busy_d;
  logic [1:0]       core_a, core_b;
  logic [3:0]       core_p;
  logic [P_W-1:0]   term;
  logic             accept;

  // No handshake can complete while reset is asserted.
  assign in_ready = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  mult2_core u_core (
    .a_i (core_a),
    .b_i (core_b),
    .p_o (core_p)
  );

  // Operand slice and shift selection per compute step.
  always_comb begin
    core_a = a_q[1:0];
    core_b = b_q[1:0];
    term   = P_W'(core_p) << SH_LL;
    case (state_q)
      ST_LH: begin
        core_b = b_q[3:2];
        term   = P_W'(core_p) << SH_LH;
      end
      ST_HL: begin
        core_a = a_q[3:2];
        term   = P_W'(core_p) << SH_HL;
      end
      ST_HH: begin
        core_a = a_q[3:2];
        core_b = b_q[3:2];
        term   = P_W'(core_p) << SH_HH;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = A;
          b_d     = B;
          acc_d   = '0;
          state_d = ST_LL;
        end
      end
      ST_LL: begin
        acc_d   = acc_q + term;
        state_d = ST_LH;
      end
      ST_LH: begin
        acc_d   = acc_q + term;
        state_d = ST_HL;
      end
      ST_HL: begin
        acc_d   = acc_q + term;
        state_d = ST_HH;
      end
      ST_HH: begin
        acc_d   = acc_q + term;
        p_d     = acc_q + term;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (accept) begin
          a_d     = A;
          b_d     = B;
          acc_d   = '0;
          state_d = ST_LL;
        end else if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign P         = p_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// Randomized and directed bench for mult4_seq_ctrl against a latency-level product model.
module tb_mult4_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] A;
  logic [3:0] B;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] P;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Model: one operation in flight, accepted in cycle t_acc, result visible from t_acc+5.
  int         cyc      = 0;
  int         t_acc    = 0;
  bit         inflight = 1'b0;
  logic [7:0] cur_prod = '0;
  logic [7:0] exp_p    = '0;

  always #5 clk = ~clk;

  mult4_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, got, want);
    end
  endtask

  task automatic step(input logic rn, input logic iv, input logic [3:0] a,
                      input logic [3:0] b, input logic ordy);
    logic rdy_exp;
    bit   done_now;
    rst_n     = rn;
    in_valid  = iv;
    A         = a;
    B         = b;
    out_ready = ordy;
    #1;
    done_now = inflight && (cyc >= t_acc + 5);
    rdy_exp  = rn && (!inflight || (done_now && ordy));
    check_eq("in_ready", 8'(in_ready), 8'(rdy_exp));
    @(posedge clk);
    if (!rn) begin
      inflight = 1'b0;
      exp_p    = '0;
    end else begin
      if (done_now && ordy) inflight = 1'b0;
      if (iv && rdy_exp) begin
        inflight = 1'b1;
        t_acc    = cyc;
        cur_prod = 8'(a) * 8'(b);
      end
    end
    cyc++;
    #1;
    if (inflight && cyc == t_acc + 5) exp_p = cur_prod;
    check_eq("out_valid", 8'(out_valid), 8'(inflight && (cyc >= t_acc + 5)));
    check_eq("busy", 8'(busy), 8'(inflight));
    check_eq("P", P, exp_p);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && busy; i++) step(1'b1, 1'b0, 4'($urandom), 4'($urandom), 1'b1);
    check_eq("drain_idle", 8'(busy), 8'd0);
  endtask

  // Accept one pair from IDLE, scribble on A/B while computing, and check product and latency.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] want,
                        input string tag);
    int n;
    drain();
    step(1'b1, 1'b1, a, b, 1'b1);
    n = 1;
    while (!out_valid && n < 12) begin
      step(1'b1, 1'b0, 4'($urandom), 4'($urandom), 1'b1);
      n++;
    end
    check_eq({tag, "_lat"}, 8'(n), 8'd5);
    check_eq({tag, "_p"}, P, want);
  endtask

  initial begin
    // Reset held with in_valid high.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd7, 4'd7, 1'b1);
    step(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);

    run_op(4'd3,  4'd5,  8'd15,  "single");
    run_op(4'd15, 4'd15, 8'd225, "max");
    run_op(4'd0,  4'd13, 8'd0,   "zero");
    run_op(4'd1,  4'd1,  8'd1,   "one");

    // Backpressure: hold DONE for 4 cycles.
    drain();
    step(1'b1, 1'b1, 4'd6, 4'd7, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'($urandom), 4'($urandom), 1'b0);
    check_eq("bp_valid", 8'(out_valid), 8'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'($urandom), 4'($urandom), 1'b0);
    check_eq("bp_p", P, 8'd42);
    step(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    check_eq("bp_idle", 8'(busy), 8'd0);

    // Back-to-back: second pair accepted in the DONE cycle of the first.
    step(1'b1, 1'b1, 4'd2, 4'd3, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'($urandom), 4'($urandom), 1'b1);
    check_eq("b2b_p1", P, 8'd6);
    check_eq("b2b_rdy", 8'(in_ready), 8'd1);
    step(1'b1, 1'b1, 4'd9, 4'd7, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'($urandom), 4'($urandom), 1'b1);
    check_eq("b2b_p2", P, 8'd63);
    check_eq("b2b_v2", 8'(out_valid), 8'd1);

    // Reset during the LH step aborts the operation.
    drain();
    step(1'b1, 1'b1, 4'd10, 4'd11, 1'b1);
    step(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    check_eq("rst_p", P, 8'd0);
    run_op(4'd4, 4'd4, 8'd16, "post_rst");

    // Random traffic with occasional resets and backpressure.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 29) != 0), 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
